// File: rtl/seq_pkg.sv
// Shared constants for the multi-cycle sequencer: states, opcodes,
// ALU op codes and instruction field positions.
package seq_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_DECODE = 3'd2;
   localparam logic [2:0] ST_EXEC   = 3'd3;
   localparam logic [2:0] ST_WB     = 3'd4;
   localparam logic [2:0] ST_HALT   = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE   = ST_IDLE,
      S_FETCH  = ST_FETCH,
      S_DECODE = ST_DECODE,
      S_EXEC   = ST_EXEC,
      S_WB     = ST_WB,
      S_HALT   = ST_HALT
   } state_e;

   localparam logic [3:0] OP_HALT = 4'b0000;
   localparam logic [3:0] OP_NOP  = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0100;
   localparam logic [3:0] OP_BZ   = 4'b1000;

   localparam logic [1:0] ALU_OFF = 2'b00;
   localparam logic [1:0] ALU_ADD = 2'b01;
   localparam logic [1:0] ALU_SUB = 2'b10;

   localparam int IR_W    = 36;
   localparam int OPC_LSB = 0;
   localparam int RD_LSB  = 4;
   localparam int RA_LSB  = 9;
   localparam int RB_LSB  = 14;
   localparam int TGT_LSB = 19;
   localparam int REG_W   = 5;

endpackage

// File: rtl/seq_decode.sv
// Opcode to control mapping; unknown opcodes decode as NOP.
module seq_decode
   import seq_pkg::*;
(
   input  logic [3:0] opcode_i,
   output logic [1:0] alu_en_o,
   output logic       wr_en_o,
   output logic       is_branch_o,
   output logic       is_halt_o
);

   always_comb begin
      alu_en_o    = ALU_OFF;
      wr_en_o     = 1'b0;
      is_branch_o = 1'b0;
      is_halt_o   = 1'b0;
      case (opcode_i)
         OP_ADD: begin
            alu_en_o = ALU_ADD;
            wr_en_o  = 1'b1;
         end
         OP_SUB: begin
            alu_en_o = ALU_SUB;
            wr_en_o  = 1'b1;
         end
         OP_BZ:   is_branch_o = 1'b1;
         OP_HALT: is_halt_o   = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_seq.sv
// FETCH/DECODE/EXEC/WB instruction sequencer owning the PC.
// Optional perf counters (retired, stall_cyc) under SEQ_PERF_CNT_EN.
module multicycle_seq
   import seq_pkg::*;
#(
   parameter int              PC_W   = 8,
   parameter logic [PC_W-1:0] RST_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            run,
   output logic [PC_W-1:0] imem_addr,
   output logic            imem_req,
   input  logic            imem_ack,
   input  logic [35:0]     imem_data,
   input  logic            z,
   output logic [1:0]      alu_en,
   output logic [4:0]      rpa,
   output logic [4:0]      rpb,
   output logic [4:0]      wpn,
   output logic            write_en,
   output logic [PC_W-1:0] pc,
`ifdef SEQ_PERF_CNT_EN
   output logic [31:0]     retired,
   output logic [31:0]     stall_cyc,
`endif
   output logic            halted
);

   state_e            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [IR_W-1:0]   ir_q, ir_d;
   logic              taken_q, taken_d;

   logic [1:0]        dec_alu;
   logic              dec_we;
   logic              dec_br;
   logic              dec_halt;
   logic              unused_ir;

   seq_decode u_dec (
      .opcode_i    (ir_q[OPC_LSB +: 4]),
      .alu_en_o    (dec_alu),
      .wr_en_o     (dec_we),
      .is_branch_o (dec_br),
      .is_halt_o   (dec_halt)
   );

   // Bits above the target field are don't-care.
   assign unused_ir = ^ir_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= RST_PC;
         ir_q    <= '0;
         taken_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         taken_q <= taken_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      taken_d  = taken_q;
      imem_req = 1'b0;
      alu_en   = ALU_OFF;
      write_en = 1'b0;
      wpn      = '0;
      halted   = 1'b0;
      case (state_q)
         S_IDLE: if (run) state_d = S_FETCH;
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               ir_d    = imem_data;
               state_d = S_DECODE;
            end
         end
         S_DECODE: state_d = dec_halt ? S_HALT : S_EXEC;
         S_EXEC: begin
            alu_en  = dec_alu;
            taken_d = dec_br & z;
            state_d = S_WB;
         end
         S_WB: begin
            write_en = dec_we;
            if (dec_we) wpn = ir_q[RD_LSB +: REG_W];
            pc_d     = taken_q ? ir_q[TGT_LSB +: PC_W] : pc_q + 1'b1;
            state_d  = run ? S_FETCH : S_IDLE;
         end
         S_HALT: halted = 1'b1;
         default: state_d = S_IDLE;
      endcase
   end

   assign rpa       = ir_q[RA_LSB +: REG_W];
   assign rpb       = ir_q[RB_LSB +: REG_W];
   assign pc        = pc_q;
   assign imem_addr = pc_q;

`ifdef SEQ_PERF_CNT_EN
   logic [31:0] retired_q, stall_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         retired_q <= '0;
         stall_q   <= '0;
      end else begin
         if (state_q == S_WB && retired_q != '1)
            retired_q <= retired_q + 1'b1;
         if (state_q == S_FETCH && !imem_ack && stall_q != '1)
            stall_q <= stall_q + 1'b1;
      end
   end

   assign retired   = retired_q;
   assign stall_cyc = stall_q;
`endif

endmodule

// File: doc/multicycle_seq.md
Name: multicycle_seq

Overview:
- Multi-cycle instruction sequencer for the 36-bit processor.
- Fetches an instruction from instruction memory over a req/ack handshake and latches it.
- Steps the datapath through FETCH, DECODE, EXEC and WB, driving register-file ports, ALU enable and write strobe, and owning the PC.
- Takes the ALU zero flag z for conditional branches; sits between imem and the register-file/ALU datapath.

Parameters:
- PC_W, 8, PC width in bits; PC wraps modulo 2^PC_W.
- RST_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- run  input  1  level; while low, the block holds in IDLE.
- imem_addr  output  PC_W  fetch address, equal to pc.
- imem_req  output  1  fetch request.
- imem_ack  input  1  fetch data valid this cycle.
- imem_data  input  36  instruction word.
- z  input  1  ALU zero flag, sampled in EXEC.
- alu_en  output  2  ALU op: 00 off, 01 add, 10 sub.
- rpa  output  5  register read port A.
- rpb  output  5  register read port B.
- wpn  output  5  register write port number.
- write_en  output  1  register-file write strobe.
- pc  output  PC_W  current program counter.
- halted  output  1  high in HALT state.

Behaviour:
- Instruction fields:
  - [3:0] opcode.
  - [8:4] rd.
  - [13:9] ra.
  - [18:14] rb.
  - [18+PC_W:19] target.
  - Remaining bits ignored.
- Opcodes:
  - 0001 NOP.
  - 0010 ADD (rd=ra+rb).
  - 0100 SUB (rd=ra-rb; z updated by ALU).
  - 1000 BZ (pc=target if z, else pc+1).
  - 0000 HALT.
  - Any other opcode is treated as NOP.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- Reset (rst_n low at a clk edge):
  - state=IDLE, pc=RST_PC, ir=0.
  - imem_req=0, alu_en=0, write_en=0, rpa=rpb=wpn=0, halted=0.
  - Reset overrides everything in any state, including mid-fetch; a pending ack is discarded.
- IDLE: run=1 moves to FETCH next cycle.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack=1, ir<=imem_data and go to DECODE.
  - With no ack, stay indefinitely with req held high; there is no timeout.
- DECODE:
  - rpa=ir.ra, rpb=ir.rb, registered and held through EXEC.
  - HALT opcode goes to HALT; all others go to EXEC.
- EXEC:
  - alu_en set by opcode: 01 ADD, 10 SUB, 00 otherwise.
  - BZ samples z this cycle.
  - Next state is WB.
- WB:
  - write_en=1 and wpn=ir.rd for ADD/SUB only; write_en is a one-cycle pulse.
  - pc update:
    - BZ taken: pc=target.
    - Otherwise: pc=pc+1, wrapping from 2^PC_W-1 to 0.
  - If run=1, go to FETCH; else go to IDLE.
- Latency: 4 cycles per instruction plus imem wait cycles (FETCH 1 + waits, DECODE, EXEC, WB).
- HALT: halted=1 and all strobes 0; exit only by reset.
- run deasserting mid-instruction has no effect until WB completes.
- alu_en is 00 in every state except EXEC; write_en is 0 in every state except WB.

Optional Feature:
- Macro SEQ_PERF_CNT_EN.
- When defined:
  - Adds output retired [31:0], incremented in WB for every completed instruction, saturating at 0xFFFFFFFF.
  - Adds output stall_cyc [31:0], incremented each FETCH cycle with imem_ack=0, also saturating.
  - Both counters clear on reset.
- When undefined: neither port nor any counter logic exists.

Decomposition:
- Shared package seq_pkg:
  - State encoding localparams.
  - Opcode constants (OP_HALT, OP_NOP, OP_ADD, OP_SUB, OP_BZ).
  - alu_en codes.
  - Field bit-position constants.
- One sub-module, seq_decode: combinational opcode-to-control mapping (alu_en, write_en intent, is_branch, is_halt).

Test Plan:
- Reset then run=1, imem_ack same cycle as req, imem_data ADD rd=3 ra=1 rb=2:
  - DECODE: rpa=1, rpb=2.
  - EXEC: alu_en=01.
  - WB: write_en=1, wpn=3.
  - pc 0 to 1.
- BZ target=0x20, z=1 in EXEC: pc=0x20 after WB, write_en stays 0.
- Same BZ with z=0: pc=pc+1.
- imem_ack withheld 3 cycles: imem_req high for 4 cycles; instruction completes 3 cycles later (SEQ_PERF_CNT_EN: stall_cyc=3).
- pc=0xFF with NOP, PC_W=8: pc wraps to 0x00.
- HALT fetched: halted=1 and stays with run=1.
- rst_n low during FETCH: next cycle state=IDLE, pc=RST_PC, halted=0, all strobes 0.
